// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D SPI responder model.
package a2d_pkg;

   localparam int CMD_W  = 16;
   localparam int DATA_W = 12;
   localparam int CH_W   = 3;

   localparam logic [2:0] CH_BATT   = 3'd0;
   localparam logic [2:0] CH_CURR   = 3'd1;
   localparam logic [2:0] CH_BRAKE  = 3'd3;
   localparam logic [2:0] CH_TORQUE = 3'd4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   // A well-formed read command carries only the channel field.
   function automatic logic cmd_malformed(input logic [CMD_W-1:0] cmd);
      return (cmd[15:14] != 2'b00) || (cmd[10:0] != 11'd0);
   endfunction

   function automatic logic [CMD_W-1:0] pack_resp(input logic [DATA_W-1:0] data);
      return {4'h0, data};
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Three-flop synchronizer for an asynchronous SPI pin with level and edge pulses.
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic lvl_o,
   output logic rise_o,
   output logic fall_o
);

   logic [2:0] sync_q;

   // Shift the pin through the metastability chain plus one history stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= {3{RST_VAL}};
      end else begin
         sync_q <= {sync_q[1:0], d_i};
      end
   end

   assign lvl_o  = sync_q[1];
   assign rise_o = sync_q[1] & ~sync_q[2];
   assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/a2d_spi_serf.sv
// SPI responder model of the 8-channel 12-bit A2D: returns the channel
// commanded in the previous transaction while capturing the next command.
import a2d_pkg::*;

module a2d_spi_serf #(
   parameter int          NUM_CH    = 8,
   parameter logic [11:0] RESET_VAL = 12'h000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   input  logic        ch_wr,
   input  logic [2:0]  ch_addr,
   input  logic [11:0] ch_wdata,
   output logic        cmd_vld,
   output logic [2:0]  last_chnnl,
   output logic        cmd_err
);

   localparam int               CNT_W    = $clog2(CMD_W + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CMD_W);

   logic ss_lvl_s, ss_rise_s, ss_fall_s;
   logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
   logic [1:0] mosi_q;

   state_t             state_q, state_d;
   logic [CMD_W-1:0]   tx_q, tx_d;
   logic [CMD_W-1:0]   rx_q, rx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CH_W-1:0]    pend_q, pend_d;
   logic [CH_W-1:0]    last_q, last_d;
   logic               err_q, err_d;
   logic               vld_q, vld_d;
   logic               miso_q, miso_d;
   logic [DATA_W-1:0]  chreg_q [NUM_CH];

   spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
      .clk    (clk),
      .rst    (rst),
      .d_i    (SS_n),
      .lvl_o  (ss_lvl_s),
      .rise_o (ss_rise_s),
      .fall_o (ss_fall_s)
   );

   spi_sync_edge #(.RST_VAL(1'b1)) u_sclk_sync (
      .clk    (clk),
      .rst    (rst),
      .d_i    (SCLK),
      .lvl_o  (sclk_lvl_s),
      .rise_o (sclk_rise_s),
      .fall_o (sclk_fall_s)
   );

   // MOSI only needs a settled level, sampled on detected SCLK rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mosi_q <= 2'b00;
      end else begin
         mosi_q <= {mosi_q[0], MOSI};
      end
   end

   // Channel holding registers, writable in every FSM state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            chreg_q[i] <= RESET_VAL;
         end
      end else if (ch_wr) begin
         chreg_q[ch_addr] <= ch_wdata;
      end
   end

   // Next-state and datapath updates for the transaction FSM.
   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      last_d  = last_q;
      err_d   = err_q;
      vld_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (ss_fall_s) begin
               state_d = LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            tx_d    = pack_resp(chreg_q[pend_q]);
            cnt_d   = {CNT_W{1'b0}};
            state_d = SHIFT;
         end
         SHIFT: begin
            if (ss_rise_s) begin
               if (cnt_q == CNT_FULL) begin
                  state_d = DONE;
                  vld_d   = 1'b1;
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               if (sclk_rise_s) begin
                  rx_d = {rx_q[CMD_W-2:0], mosi_q[1]};
                  if (cnt_q != CNT_FULL) begin
                     cnt_d = cnt_q + 1'b1;
                  end else begin
                     cnt_d = cnt_q;
                  end
               end else begin
                  rx_d = rx_q;
               end
               // The leading fall precedes the first sample, so MSB stays put.
               if (sclk_fall_s && (cnt_q != {CNT_W{1'b0}})) begin
                  tx_d = {tx_q[CMD_W-2:0], 1'b0};
               end else begin
                  tx_d = tx_q;
               end
            end
         end
         DONE: begin
            last_d  = rx_q[13:11];
            pend_d  = rx_q[13:11];
            if (cmd_malformed(rx_q)) begin
               err_d = 1'b1;
            end else begin
               err_d = err_q;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      miso_d = (~ss_lvl_s) & tx_d[CMD_W-1];
   end

   // FSM and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tx_q    <= {CMD_W{1'b0}};
         rx_q    <= {CMD_W{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         pend_q  <= {CH_W{1'b0}};
         last_q  <= {CH_W{1'b0}};
         err_q   <= 1'b0;
         vld_q   <= 1'b0;
         miso_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         last_q  <= last_d;
         err_q   <= err_d;
         vld_q   <= vld_d;
         miso_q  <= miso_d;
      end
   end

   assign MISO       = miso_q;
   assign cmd_vld    = vld_q;
   assign last_chnnl = last_q;
   assign cmd_err    = err_q;

endmodule

// File: tb/tb_a2d_spi_serf.sv
// Directed and randomized SPI frames against a channel-table reference model.
module tb_a2d_spi_serf;
   import a2d_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;
   logic        ch_wr;
   logic [2:0]  ch_addr;
   logic [11:0] ch_wdata;
   logic        cmd_vld;
   logic [2:0]  last_chnnl;
   logic        cmd_err;

   int n_cmp = 0;
   int n_bad = 0;
   int vld_cnt = 0;

   logic [11:0] chm [8];
   logic [2:0]  pend_m;
   logic [2:0]  last_m;
   logic        err_m;

   a2d_spi_serf #(.NUM_CH(8), .RESET_VAL(12'h000)) dut (
      .clk        (clk),
      .rst        (rst),
      .SS_n       (SS_n),
      .SCLK       (SCLK),
      .MOSI       (MOSI),
      .MISO       (MISO),
      .ch_wr      (ch_wr),
      .ch_addr    (ch_addr),
      .ch_wdata   (ch_wdata),
      .cmd_vld    (cmd_vld),
      .last_chnnl (last_chnnl),
      .cmd_err    (cmd_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cmd_vld === 1'b1) vld_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [2:0] ch, input logic [11:0] val);
      @(negedge clk);
      ch_wr = 1'b1; ch_addr = ch; ch_wdata = val;
      @(negedge clk);
      ch_wr = 1'b0;
      chm[ch] = val;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) chm[i] = 12'h000;
      pend_m = 3'd0; last_m = 3'd0; err_m = 1'b0;
   endtask

   function automatic logic [15:0] rd_cmd(input logic [2:0] ch);
      return 16'(ch) * 16'd2048;
   endfunction

   // One SPI frame: SCLK falls (MOSI changes) then rises (both sides sample).
   task automatic frame(input logic [31:0] bits, input int nrise, input int mid_at,
                        input logic [2:0] mid_ch, input logic [11:0] mid_val, input string tag);
      logic [15:0] resp, exp_resp, cmd;
      int v0;
      exp_resp = {4'h0, chm[pend_m]};
      v0 = vld_cnt;
      resp = 16'h0000;
      @(negedge clk);
      SS_n = 1'b0;
      wait_clk(16);
      for (int i = 0; i < nrise; i++) begin
         SCLK = 1'b0;
         MOSI = bits[nrise-1-i];
         wait_clk(8);
         if (i == mid_at) wr(mid_ch, mid_val);
         else wait_clk(2);
         wait_clk(6);
         if (i < 16) resp[15-i] = MISO;
         SCLK = 1'b1;
         wait_clk(16);
      end
      SS_n = 1'b0;
      SS_n = 1'b1;
      MOSI = 1'b0;
      wait_clk(16);
      if (nrise >= 16) begin
         cmd = bits[15:0];
         check({tag, "_resp"}, 32'(resp), 32'(exp_resp));
         last_m = (cmd >> 11) % 8;
         pend_m = last_m;
         if ((cmd >> 14) != 16'd0 || (cmd % 16'd2048) != 16'd0) err_m = 1'b1;
         check({tag, "_vld"}, 32'(vld_cnt - v0), 32'd1);
      end else begin
         err_m = 1'b1;
         check({tag, "_novld"}, 32'(vld_cnt - v0), 32'd0);
      end
      check({tag, "_last"}, 32'(last_chnnl), 32'(last_m));
      check({tag, "_err"}, 32'(cmd_err), 32'(err_m));
   endtask

   initial begin
      logic [15:0] cmd;
      logic [31:0] bits;
      logic [2:0]  c3;
      int          sel;
      int          nr;

      rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
      ch_wr = 1'b0; ch_addr = 3'd0; ch_wdata = 12'h000;
      model_reset();
      wait_clk(5);
      check("rst_miso", 32'(MISO), 32'd0);
      check("rst_vld", 32'(cmd_vld), 32'd0);
      check("rst_last", 32'(last_chnnl), 32'd0);
      check("rst_err", 32'(cmd_err), 32'd0);
      rst = 1'b0;
      wait_clk(5);

      // Pipelined basic read of channel 0.
      wr(CH_BATT, 12'hA5C);
      frame(32'(rd_cmd(CH_BATT)), 16, -1, 3'd0, 12'h000, "f1");
      frame(32'(rd_cmd(CH_BATT)), 16, -1, 3'd0, 12'h000, "f2");

      // Round-robin over the sensor channels.
      wr(CH_CURR, 12'h123); wr(CH_BRAKE, 12'h7FF); wr(CH_TORQUE, 12'h800);
      frame(32'(rd_cmd(CH_CURR)),   16, -1, 3'd0, 12'h000, "rr1");
      frame(32'(rd_cmd(CH_BRAKE)),  16, -1, 3'd0, 12'h000, "rr3");
      frame(32'(rd_cmd(CH_TORQUE)), 16, -1, 3'd0, 12'h000, "rr4");
      frame(32'(rd_cmd(CH_BATT)),   16, -1, 3'd0, 12'h000, "rr0");
      frame(32'(rd_cmd(CH_BATT)),   16, -1, 3'd0, 12'h000, "rr0b");

      // Write before LOAD is visible; write during SHIFT is not.
      frame(32'(rd_cmd(CH_BRAKE)), 16, -1, 3'd0, 12'h000, "w3a");
      wr(CH_BRAKE, 12'h055);
      frame(32'(rd_cmd(CH_BRAKE)), 16, 4, CH_BRAKE, 12'h3AA, "w3b");
      frame(32'(rd_cmd(CH_BATT)), 16, -1, 3'd0, 12'h000, "w3c");

      // Abort after 9 rises keeps the pending channel.
      frame(32'(rd_cmd(CH_BRAKE)), 16, -1, 3'd0, 12'h000, "ab0");
      frame(32'(rd_cmd(CH_CURR)), 9, -1, 3'd0, 12'h000, "abort");
      wr(3'd2, 12'hFFF);
      frame(32'(rd_cmd(3'd2)), 16, -1, 3'd0, 12'h000, "ab1");

      // Reset in the middle of a frame returning 12'hFFF.
      @(negedge clk);
      SS_n = 1'b0;
      wait_clk(16);
      for (int i = 0; i < 5; i++) begin
         SCLK = 1'b0; MOSI = 1'b0; wait_clk(16);
         SCLK = 1'b1; wait_clk(16);
      end
      SCLK = 1'b0;
      wait_clk(16);
      check("pre_rst_miso", 32'(MISO), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_miso", 32'(MISO), 32'd0);
      check("mid_rst_last", 32'(last_chnnl), 32'd0);
      check("mid_rst_err", 32'(cmd_err), 32'd0);
      check("mid_rst_vld", 32'(cmd_vld), 32'd0);
      model_reset();
      SS_n = 1'b1; SCLK = 1'b1;
      wait_clk(5);
      rst = 1'b0;
      wait_clk(5);
      frame(32'(rd_cmd(CH_CURR)), 16, -1, 3'd0, 12'h000, "pr1");
      frame(32'(rd_cmd(CH_BATT)), 16, -1, 3'd0, 12'h000, "pr2");

      // Malformed command still selects its channel.
      wr(CH_CURR, 12'h9B4);
      frame(32'h0000C800, 16, -1, 3'd0, 12'h000, "bad");
      frame(32'(rd_cmd(CH_BATT)), 16, -1, 3'd0, 12'h000, "bad_nx");

      // More than 16 rises: only the last 16 bits form the command.
      frame({14'h0, 2'b11, rd_cmd(CH_TORQUE)}, 18, -1, 3'd0, 12'h000, "long");
      frame(32'(rd_cmd(CH_BATT)), 16, -1, 3'd0, 12'h000, "long_nx");

      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(0, 1) == 1) wr(3'($urandom_range(0, 7)), 12'($urandom));
         sel = int'($urandom_range(0, 7));
         c3 = 3'($urandom_range(0, 7));
         cmd = rd_cmd(c3);
         if (sel == 5) cmd = 16'($urandom);
         bits = 32'(cmd);
         nr = 16;
         if (sel == 6) begin
            nr = int'($urandom_range(17, 19));
            bits = {16'($urandom), cmd};
         end else if (sel == 7) begin
            nr = int'($urandom_range(3, 15));
         end
         frame(bits, nr, -1, 3'd0, 12'h000, "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
